// File: rtl/jk_pkg.sv
// Purpose: shared mode encodings for the JK register bank.
// Latency: n/a (constants only).
// Backpressure: none; no flow control in this block.
package jk_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;  // per-bit J/K pass-through
    localparam logic [1:0] MODE_UP = 2'b01;  // binary up-counter
    localparam logic [1:0] MODE_DN = 2'b10;  // binary down-counter
    localparam logic [1:0] MODE_SH = 2'b11;  // shift left, serial input into bit 0

endpackage

// File: rtl/jk_cell.sv
// Purpose: single JK flip-flop with update enable and synchronous reset value.
// Latency: one clock from j/k to q.
// Backpressure: none; en=0 holds state.
// Ports: clk, rst (sync, active-high), en, j, k -> q.
module jk_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Purpose: bank of WIDTH JK cells operating as JK register, up/down counter or shifter.
// Latency: one clock inputs->q, zero q/mode->tc, one clock q change->chg.
// Backpressure: none; en=0 holds all state and clears chg.
// Ports: clk, rst, en, mode[1:0], j/k[WIDTH-1:0] -> q, qb, tc, chg.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             chg
);

    logic [WIDTH-1:0] up_t;       // bit toggles when all lower bits are 1
    logic [WIDTH-1:0] dn_t;       // bit toggles when all lower bits are 0
    logic [WIDTH-1:0] shift_src;  // value each bit takes in shift mode
    logic [WIDTH-1:0] eff_j;
    logic [WIDTH-1:0] eff_k;
    logic [WIDTH-1:0] flip;       // bits that will change on the next enabled edge
    logic             sin;

    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    assign sin       = j[0] & ~k[0];
    assign shift_src = {q[WIDTH-2:0], sin};

    // Every mode is mapped onto per-cell J/K: counting uses J=K=toggle,
    // shifting uses set/clear from the neighbour so each cell loads a value.
    always_comb begin
        eff_j = j;
        eff_k = k;
        case (mode)
            MODE_UP: begin
                eff_j = up_t;
                eff_k = up_t;
            end
            MODE_DN: begin
                eff_j = dn_t;
                eff_k = dn_t;
            end
            MODE_SH: begin
                eff_j = shift_src;
                eff_k = ~shift_src;
            end
            default: begin
                eff_j = j;
                eff_k = k;
            end
        endcase
    end

    // A cell changes exactly when it is set while 0 or cleared/toggled while 1.
    assign flip = (eff_j & ~q) | (eff_k & q);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .RST_VAL (RST_VAL[gi])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .j   (eff_j[gi]),
            .k   (eff_k[gi]),
            .q   (q[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chg <= 1'b0;
        end else if (en) begin
            chg <= |flip;
        end else begin
            chg <= 1'b0;
        end
    end

    assign qb = ~q;
    assign tc = ((mode == MODE_UP) && (&q)) || ((mode == MODE_DN) && (~|q));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Purpose: self-checking bench for jk_reg_bank (WIDTH=4, RST_VAL=0).
// Latency: n/a.
// Backpressure: n/a.
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] j = 4'h0;
    logic [3:0] k = 4'h0;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
    logic       chg;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [3:0] m_q = 4'h0;
    logic       m_chg = 1'b0;
    logic       m_valid = 1'b0;

    jk_reg_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .j    (j),
        .k    (k),
        .q    (q),
        .qb   (qb),
        .tc   (tc),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tc(input logic [1:0] md, input logic [3:0] v);
        return (md == 2'b01 && v == 4'd15) || (md == 2'b10 && v == 4'd0);
    endfunction

    // Next-state rules written as plain arithmetic on the whole word.
    task automatic model_edge();
        logic [3:0] nq;
        nq = m_q;
        if (rst) begin
            m_q   = 4'h0;
            m_chg = 1'b0;
            m_valid = 1'b1;
        end else if (!en) begin
            m_chg = 1'b0;
        end else begin
            case (mode)
                2'b00: for (int i = 0; i < 4; i++) begin
                    if (j[i] && k[i])       nq[i] = ~m_q[i];
                    else if (j[i])          nq[i] = 1'b1;
                    else if (k[i])          nq[i] = 1'b0;
                end
                2'b01: nq = m_q + 4'd1;
                2'b10: nq = m_q - 4'd1;
                default: nq = {m_q[2:0], j[0] & ~k[0]};
            endcase
            m_chg = (nq != m_q);
            m_q   = nq;
        end
    endtask

    task automatic compare_all();
        chk("q",   {28'd0, q},   {28'd0, m_q});
        chk("qb",  {28'd0, qb},  {28'd0, ~m_q});
        chk("chg", {31'd0, chg}, {31'd0, m_chg});
        chk("tc",  {31'd0, tc},  {31'd0, model_tc(mode, m_q)});
    endtask

    // Apply inputs, check combinational tc before the edge, then check all after.
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [3:0] jv, input logic [3:0] kv);
        rst = r; en = e; mode = md; j = jv; k = kv;
        #1;
        if (m_valid) chk("tc_pre", {31'd0, tc}, {31'd0, model_tc(md, m_q)});
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        @(negedge clk);

        // Reset with shift mode and J all ones
        step(1, 1, 2'b11, 4'hF, 4'h0);
        chk("lit_rst_q", {28'd0, q}, 32'h0);
        chk("lit_rst_qb", {28'd0, qb}, 32'hF);
        chk("lit_rst_chg", {31'd0, chg}, 32'h0);

        // JK: set, toggle, clear, hold, then hold all
        step(0, 1, 2'b00, 4'b1010, 4'b0110);
        chk("lit_jk_q", {28'd0, q}, 32'hA);
        chk("lit_jk_chg", {31'd0, chg}, 32'h1);
        step(0, 1, 2'b00, 4'b0000, 4'b0000);
        chk("lit_jk_hold_q", {28'd0, q}, 32'hA);
        chk("lit_jk_hold_chg", {31'd0, chg}, 32'h0);

        // Up-count over a full wrap; j/k noise must be ignored
        step(1, 0, 2'b01, 4'h0, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 2'b01, 4'($urandom), 4'($urandom));
            chk("lit_up_q", {28'd0, q}, 32'(i % 16));
            chk("lit_up_chg", {31'd0, chg}, 32'h1);
            chk("lit_up_tc", {31'd0, tc}, 32'((i % 16) == 15));
        end

        // Down-count wrap from zero, then hold with en=0
        step(1, 0, 2'b10, 4'h0, 4'h0);
        step(0, 1, 2'b10, 4'h5, 4'h3);
        chk("lit_dn_q", {28'd0, q}, 32'hF);
        chk("lit_dn_tc", {31'd0, tc}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'b10, 4'($urandom), 4'($urandom));
            chk("lit_hold_q", {28'd0, q}, 32'hF);
            chk("lit_hold_chg", {31'd0, chg}, 32'h0);
        end

        // Shift with serial-input gating by k[0]
        step(1, 1, 2'b00, 4'h0, 4'h0);
        step(0, 1, 2'b11, 4'b0001, 4'b1110);
        chk("lit_sh1", {28'd0, q}, 32'h1);
        step(0, 1, 2'b11, 4'b1111, 4'b0001);
        chk("lit_sh2", {28'd0, q}, 32'h2);
        step(0, 1, 2'b11, 4'b0001, 4'b0000);
        chk("lit_sh3", {28'd0, q}, 32'h5);
        step(0, 1, 2'b11, 4'b1110, 4'b0000);
        chk("lit_sh4", {28'd0, q}, 32'hA);

        // Reset in the middle of a count
        step(1, 1, 2'b00, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 2'b01, 4'h0, 4'h0);
        chk("lit_mid_q", {28'd0, q}, 32'h6);
        step(1, 1, 2'b01, 4'h0, 4'h0);
        chk("lit_mid_rst_q", {28'd0, q}, 32'h0);
        chk("lit_mid_rst_chg", {31'd0, chg}, 32'h0);
        step(0, 1, 2'b01, 4'h0, 4'h0);
        chk("lit_mid_after_q", {28'd0, q}, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0),
                 2'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
